// File: rtl/mix_columns_pipe_if.sv
// rtl/mix_columns_pipe_if.sv - handshake bundle for the mix_columns_pipe input and output streams
interface mix_columns_pipe_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_vld;
  logic          in_rdy;
  logic          in_mc_off;
  logic          in_inv;
  logic [DW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic          out_state_last;

  modport master (
    output in_data, in_vld, in_mc_off, in_inv, out_rdy,
    input  in_rdy, out_data, out_vld, out_state_last
  );

  modport slave (
    input  in_data, in_vld, in_mc_off, in_inv, out_rdy,
    output in_rdy, out_data, out_vld, out_state_last
  );
endinterface

// File: rtl/mix_columns_pipe.sv
// rtl/mix_columns_pipe.sv - two-stage AES MixColumns pipeline, COLS 32-bit columns per beat
// Define INV_MIX_COLUMNS_EN to add the InvMixColumns datapath selected by in_inv.
module mix_columns_pipe #(
  parameter int COLS = 1
) (
  input logic               clk,
  input logic               rst_n,
  mix_columns_pipe_if.slave bus
);
  localparam int         DW        = 32 * COLS;
  localparam logic [1:0] LAST_BEAT = 2'(4 / COLS - 1);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef INV_MIX_COLUMNS_EN
  // InvMixColumns = MixColumns applied after folding in {04,00,05,00}; shares the forward network.
  function automatic logic [31:0] inv_pre(input logic [31:0] col);
    logic [7:0] u, v;
    u = xtime(xtime(col[31:24] ^ col[15:8]));
    v = xtime(xtime(col[23:16] ^ col[7:0]));
    return {col[31:24] ^ u, col[23:16] ^ v, col[15:8] ^ u, col[7:0] ^ v};
  endfunction
`endif

  logic          s1_vld;
  logic          s1_off;
  logic [DW-1:0] s1_data;
`ifdef INV_MIX_COLUMNS_EN
  logic          s1_inv;
`endif
  logic          s2_vld;
  logic [DW-1:0] s2_data;
  logic [DW-1:0] s2_next;
  logic [1:0]    beat_cnt;

  logic s2_load;
  logic s1_adv;
  logic in_rdy;
  logic in_xfer;
  logic out_xfer;

  assign s2_load  = !s2_vld || bus.out_rdy;
  assign s1_adv   = s1_vld && s2_load;
  assign in_rdy   = !s1_vld || s1_adv;
  assign in_xfer  = bus.in_vld && in_rdy;
  assign out_xfer = s2_vld && bus.out_rdy;

  assign bus.in_rdy         = in_rdy;
  assign bus.out_vld        = s2_vld;
  assign bus.out_data       = s2_vld ? s2_data : '0;
  assign bus.out_state_last = s2_vld && (beat_cnt == LAST_BEAT);

  always_comb begin
    s2_next = s1_data;
    if (!s1_off) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef INV_MIX_COLUMNS_EN
        s2_next[32*c +: 32] = mix_fwd(s1_inv ? inv_pre(s1_data[32*c +: 32])
                                             : s1_data[32*c +: 32]);
`else
        s2_next[32*c +: 32] = mix_fwd(s1_data[32*c +: 32]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_off   <= 1'b0;
      s1_data  <= '0;
`ifdef INV_MIX_COLUMNS_EN
      s1_inv   <= 1'b0;
`endif
      s2_vld   <= 1'b0;
      s2_data  <= '0;
      beat_cnt <= 2'd0;
    end else begin
      if (in_xfer) begin
        s1_vld  <= 1'b1;
        s1_data <= bus.in_data;
        s1_off  <= bus.in_mc_off;
`ifdef INV_MIX_COLUMNS_EN
        s1_inv  <= bus.in_inv;
`endif
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end

      if (s2_load) begin
        s2_vld  <= s1_vld;
        s2_data <= s2_next;
      end

      if (out_xfer) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? 2'd0 : beat_cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mix_columns_pipe.sv
// tb/tb_mix_columns_pipe.sv - self-checking bench for mix_columns_pipe (COLS=1 and COLS=4 instances)
// Honours INV_MIX_COLUMNS_EN the same way as the design build.
module tb_mix_columns_pipe;
`ifdef INV_MIX_COLUMNS_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_columns_pipe_if #(.DW(32))  b1 ();
  mix_columns_pipe_if #(.DW(128)) b4 ();

  mix_columns_pipe #(.COLS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mix_columns_pipe #(.COLS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: generic carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] col, input bit off, input bit inv);
    logic [7:0]  coef [4];
    logic [7:0]  a [4];
    logic [7:0]  o;
    logic [31:0] r;
    if (off) return col;
    if (inv && INV_EN) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else               coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int j = 0; j < 4; j++) a[j] = col[31 - 8*j -: 8];
    r = 32'h0;
    for (int row = 0; row < 4; row++) begin
      o = 8'h0;
      for (int j = 0; j < 4; j++) o = o ^ gmul(coef[(j - row + 4) % 4], a[j]);
      r[31 - 8*row -: 8] = o;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_beat4(input logic [127:0] d, input bit off, input bit inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = ref_col(d[32*c +: 32], off, inv);
    return r;
  endfunction

  // Scoreboard for the COLS=1 instance, sampled on the falling edge.
  logic [31:0] q1 [$];
  int          sb_idx1 = 0;
  int          occ = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      sb_idx1    = 0;
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      if (!b1.out_vld) check("idle_zero", {b1.out_data, b1.out_state_last}, '0);
      if (prev_stall)
        check("stall_hold", {b1.out_vld, b1.out_state_last, b1.out_data}, {1'b1, prev_last, prev_data});
      check("in_rdy", b1.in_rdy, !(occ == 2 && !b1.out_rdy));
      if (b1.out_vld && b1.out_rdy) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", b1.out_data);
        end else begin
          check("sb_data", b1.out_data, q1.pop_front());
          check("sb_state_last", b1.out_state_last, (sb_idx1 % 4) == 3);
          sb_idx1++;
        end
      end
      if (b1.in_vld && b1.in_rdy) q1.push_back(ref_col(b1.in_data, b1.in_mc_off, b1.in_inv));
      occ = occ + int'(b1.in_vld && b1.in_rdy) - int'(b1.out_vld && b1.out_rdy);
      prev_stall = b1.out_vld && !b1.out_rdy;
      prev_data  = b1.out_data;
      prev_last  = b1.out_state_last;
    end
  end

  task automatic send1(input logic [31:0] d, input bit off, input bit inv);
    int n;
    n = 0;
    b1.in_data   = d;
    b1.in_mc_off = off;
    b1.in_inv    = inv;
    b1.in_vld    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.in_rdy && n < 200);
    if (!b1.in_rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_rdy=0 expected in_rdy=1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    b1.in_vld = 1'b0;
  endtask

  task automatic drain1();
    int n;
    n = 0;
    b1.out_rdy = 1'b1;
    while (q1.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out1(output bit seen);
    int n;
    n = 0;
    while (!b1.out_vld && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    seen = b1.out_vld;
  endtask

  typedef struct {
    logic [31:0] din;
    bit          off;
    bit          inv;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];
  bit   done;
  bit   seen;

  initial begin
    tbl[0] = '{32'hF20A225C, 1'b0, 1'b0, 32'h9FDC589D};
`ifdef INV_MIX_COLUMNS_EN
    tbl[1] = '{32'h8E4DA1BC, 1'b0, 1'b1, 32'hDB135345};
    tbl[2] = '{32'h9FDC589D, 1'b0, 1'b1, 32'hF20A225C};
`else
    tbl[1] = '{32'h8E4DA1BC, 1'b0, 1'b1, ref_col(32'h8E4DA1BC, 1'b0, 1'b0)};
    tbl[2] = '{32'h9FDC589D, 1'b0, 1'b1, ref_col(32'h9FDC589D, 1'b0, 1'b0)};
`endif
    tbl[3] = '{32'h01234567, 1'b1, 1'b1, 32'h01234567};
    tbl[4] = '{32'h01010101, 1'b0, 1'b0, 32'h01010101};
    tbl[5] = '{32'hC6C6C6C6, 1'b0, 1'b1, 32'hC6C6C6C6};
    tbl[6] = '{32'h00000000, 1'b0, 1'b0, 32'h00000000};

    b1.in_data = '0; b1.in_vld = 1'b0; b1.in_mc_off = 1'b0; b1.in_inv = 1'b0; b1.out_rdy = 1'b1;
    b4.in_data = '0; b4.in_vld = 1'b0; b4.in_mc_off = 1'b0; b4.in_inv = 1'b0; b4.out_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", {b1.out_vld, b4.out_vld}, 2'b00);
    check("rst_out_data", {b1.out_data, b4.out_state_last, b1.out_state_last}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_rdy", {b1.in_rdy, b4.in_rdy}, 2'b11);
    check("rel_out", {b1.out_vld, b4.out_vld, b4.out_data}, '0);

    // Latency: transfer at one edge, result visible after the following edge.
    b1.in_data = 32'hDB135345; b1.in_mc_off = 1'b0; b1.in_inv = 1'b0; b1.in_vld = 1'b1;
    @(posedge clk);
    #1;
    b1.in_vld = 1'b0;
    check("lat_stage1_vld", b1.out_vld, 1'b0);
    @(posedge clk);
    #1;
    check("lat_stage2_vld", b1.out_vld, 1'b1);
    check("lat_data", b1.out_data, 32'h8E4DA1BC);

    for (int i = 0; i < 7; i++) begin
      send1(tbl[i].din, tbl[i].off, tbl[i].inv);
      wait_out1(seen);
      check($sformatf("tbl%0d_vld", i), seen, 1'b1);
      check($sformatf("tbl%0d_data", i), b1.out_data, tbl[i].exp);
    end
    drain1();

    // Back-to-back beats with out_rdy toggling every cycle.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send1($urandom, 1'b0, 1'($urandom_range(0, 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          b1.out_rdy = ~b1.out_rdy;
        end
      end
    join
    drain1();

    // Random traffic with input gaps and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send1($urandom, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          b1.out_rdy = 1'($urandom_range(0, 2) != 0);
        end
      end
    join
    drain1();

    // Reset with two beats held in the pipe; beat counter sits mid-state.
    send1(32'h11223344, 1'b0, 1'b0);
    drain1();
    b1.out_rdy = 1'b0;
    send1(32'hAABBCCDD, 1'b0, 1'b0);
    send1(32'h55667788, 1'b0, 1'b0);
    check("pre_rst_vld", {b1.out_vld, b1.in_rdy}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {b1.out_vld, b1.out_state_last, b1.out_data}, '0);
    check("async_rst_in_rdy", b1.in_rdy, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b1.out_rdy = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", b1.out_vld, 1'b0);
    end
    for (int i = 0; i < 4; i++) send1($urandom, 1'b0, 1'b0);
    drain1();

    // COLS=4 instance.
    check("c4_idle_zero", {b4.out_vld, b4.out_state_last, b4.out_data}, '0);
    for (int i = 0; i < 4; i++) begin
      logic [127:0] d4, e4;
      bit o4, v4;
      int n;
      if (i == 0) begin
        d4 = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
        o4 = 1'b0;
        v4 = 1'b0;
        e4 = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
      end else begin
        d4 = {$urandom, $urandom, $urandom, $urandom};
        o4 = (i == 3);
        v4 = 1'($urandom_range(0, 1));
        e4 = ref_beat4(d4, o4, v4);
      end
      b4.in_data = d4; b4.in_mc_off = o4; b4.in_inv = v4; b4.in_vld = 1'b1;
      @(posedge clk);
      #1;
      b4.in_vld = 1'b0;
      n = 0;
      while (!b4.out_vld && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("c4_%0d_vld_last", i), {b4.out_vld, b4.out_state_last}, 2'b11);
      check($sformatf("c4_%0d_data", i), b4.out_data, e4);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mix_columns_pipe.md
MIX_COLUMNS_PIPE -- requirements
Module: mix_columns_pipe

Interface
REQ-001 Parameter COLS, default 1: number of 32-bit state columns processed per beat; legal values 1, 2, 4.
REQ-002 Parameter DW, default 32*COLS: data width; derived, not overridden.
REQ-003 clk  input  1  single block clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  DW  input columns; column c in bits [32*c+31:32*c]; within a column, byte0 = bits [31:24] … byte3 = bits [7:0].
REQ-006 in_vld  input  1  in_data and side-band are valid.
REQ-007 in_rdy  output  1  block accepts the beat this cycle.
REQ-008 in_mc_off  input  1  final round: pass data through unmodified.
REQ-009 in_inv  input  1  apply InvMixColumns instead of MixColumns.
REQ-010 out_data  output  DW  transformed columns, same layout as in_data.
REQ-011 out_vld  output  1  out_data valid.
REQ-012 out_rdy  input  1  downstream accepts out_data.
REQ-013 out_state_last  output  1  beat completes a 128-bit state (4/COLS beats).

Function
REQ-014 Transfer on a port occurs only when vld and rdy are both high at a rising edge.
REQ-015 Two-register pipeline: S1 captures in_data, in_mc_off and in_inv; S2 holds the computed result; latency from input transfer to out_vld is 2 cycles.
REQ-016 Throughput is one beat per cycle when out_rdy is held high.
REQ-017 S2 loads when S2 is empty or out_rdy is high; S1 loads when S1 is empty or S1 advances into S2; in_rdy = !S1_vld || S1_advance.
REQ-018 in_rdy does not depend combinationally on in_vld.
REQ-019 out_data, out_vld and out_state_last hold stable while out_vld=1 and out_rdy=0.
REQ-020 Forward mode per column: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3 over GF(2^8), modulus 0x11B.
REQ-021 xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00), 8-bit result.
REQ-022 Inverse mode per column uses coefficients {0E,0B,0D,09} in the same circulant arrangement.
REQ-023 in_mc_off=1 overrides in_inv; out_data equals the captured input.
REQ-024 A beat counter (width 2) increments on each output transfer and wraps from 4/COLS-1 to 0; out_state_last = out_vld && counter==4/COLS-1; for COLS=4, out_state_last = out_vld.
REQ-025 When out_vld=0, out_data is driven to all zeros.
REQ-026 Mode bits are sampled per beat; mixed modes in consecutive beats are legal and processed independently.

Reset
REQ-027 rst_n low asynchronously clears S1/S2 valid flags, beat counter and data registers; out_vld=0, out_data=0, out_state_last=0, in_rdy=1 once reset is released.
REQ-028 Reset asserted mid-operation discards all in-flight beats; no beat emerges after release unless newly accepted.

Configuration
REQ-029 Macro INV_MIX_COLUMNS_EN defined: inverse datapath is present and in_inv is honoured.
REQ-030 INV_MIX_COLUMNS_EN undefined: the in_inv port remains but is ignored; only the forward and bypass modes exist.

Verification
REQ-031 COLS=1, in_data=0xDB135345, mc_off=0, inv=0 -> out_data=0x8E4DA1BC exactly 2 cycles after the input transfer.
REQ-032 INV_MIX_COLUMNS_EN defined, in_data=0x8E4DA1BC, inv=1 -> 0xDB135345; same stimulus with the macro undefined -> forward result of 0x8E4DA1BC.
REQ-033 COLS=4, columns {DB135345, F20A225C, 01010101, C6C6C6C6} -> {8E4DA1BC, 9FDC589D, 01010101, C6C6C6C6}, with out_state_last=1.
REQ-034 mc_off=1, inv=1, in_data=0x01234567 -> out_data=0x01234567.
REQ-035 COLS=1, 8 back-to-back beats with out_rdy toggling 1/0 each cycle -> no loss or duplication, order preserved, out_state_last on beats 4 and 8, in_rdy low only while both stages are full and stalled.
REQ-036 Assert rst_n low with 2 beats in flight -> out_vld falls immediately; after release, no stale beat appears and the counter restarts at 0.
